// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: PC generation, in-order imem request/response
// tracking with stale-response dropping after redirects, and a small
// instruction buffer presenting {pc, raw word} to the decoder.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_raw,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [31:0]      buf_pc_q  [FIFO_DEPTH];
  logic [31:0]      buf_raw_q [FIFO_DEPTH];

  logic             req_fire;
  logic             rsp_take;
  logic             rsp_push;
  logic             pop;
  logic             credit_ok;
  logic [31:0]      target;
  logic [OUT_W-1:0] live_cnt;
  logic [SUM_W-1:0] credit_used;

  assign imem_req_addr = fetch_pc_q;

  // Handshake qualification and issue credit (every live response owns a buffer slot)
  always_comb begin
    target         = redirect_pc & 32'hFFFF_FFFC;
    live_cnt       = out_cnt_q - drop_cnt_q;
    credit_used    = SUM_W'(live_cnt) + SUM_W'(fifo_cnt_q);
    credit_ok      = credit_used < SUM_W'(FIFO_DEPTH);
    imem_req_valid = (state_q != ST_BOOT) && !redirect_valid &&
                     (out_cnt_q < OUT_W'(MAX_OUTSTANDING)) && credit_ok;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (out_cnt_q != '0);
    rsp_push       = rsp_take && !redirect_valid && (drop_cnt_q == '0);
    inst_valid     = fifo_cnt_q != '0;
    pop            = inst_valid && inst_ready;
  end

  // Next-state logic: PCs, counters, buffer pointers and FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + OUT_W'(req_fire) - OUT_W'(rsp_take);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(rsp_push) - CNT_W'(pop);

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (rsp_take && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OUT_W'(1);

    // Redirect overrides everything: restart at target, flush, mark in-flight stale
    if (redirect_valid) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
      drop_cnt_d = out_cnt_q - OUT_W'(rsp_take);
    end

    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (redirect_valid && (out_cnt_d != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (!redirect_valid && (drop_cnt_d == '0)) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Instruction buffer storage, written on each live response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc_q[i]  <= '0;
        buf_raw_q[i] <= '0;
      end
    end else if (rsp_push) begin
      buf_pc_q[wr_ptr_q]  <= rsp_pc_q;
      buf_raw_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // Head presentation, zeroed when the buffer is empty
  always_comb begin
    inst_pc  = '0;
    inst_raw = '0;
    if (inst_valid) begin
      inst_pc  = buf_pc_q[rd_ptr_q];
      inst_raw = buf_raw_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: directed scenarios plus random traffic checked
// against a stream-level model (expected fetch address, expected delivered PC,
// in-flight requests tagged live/stale, buffered-instruction count).
module tb_rv32i_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_raw;
  logic [31:0] inst_pc;
  logic        inst_ready;

  rv32i_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_raw       (inst_raw),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } req_t;

  req_t        mq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stream;
  int          exp_fifo;
  bit          boot;
  bit          rand_mode;
  bit          d_req_ready;
  bit          d_inst_ready;
  bit          d_redirect;
  logic [31:0] d_redirect_pc;
  int          d_delay;
  int          fires;
  int          pops;
  logic [31:0] last_pop_pc;

  // Instruction memory content as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: drive inputs, sample outputs, compare against model, advance model
  task automatic body();
    int          live_cnt;
    bit          exp_rv;
    bit          fire;
    bit          mpop;
    logic [31:0] tgt;
    req_t        e;

    if (rand_mode) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom();
    end else begin
      imem_req_ready = d_req_ready;
      inst_ready     = d_inst_ready;
      redirect_valid = d_redirect;
      redirect_pc    = d_redirect_pc;
    end
    d_redirect = 1'b0;
    if (boot) redirect_valid = 1'b0;

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end

    #1;
    live_cnt = 0;
    foreach (mq[i]) if (mq[i].live) live_cnt++;
    exp_rv = !boot && !redirect_valid && (mq.size() < 2) && ((live_cnt + exp_fifo) < 2);

    check32("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check32("req_addr", imem_req_addr, exp_fetch);
    check32("inst_valid", 32'(inst_valid), 32'(exp_fifo != 0));
    if (exp_fifo == 0) begin
      check32("idle_pc", inst_pc, 32'd0);
      check32("idle_raw", inst_raw, 32'd0);
    end

    mpop = (exp_fifo != 0) && inst_ready;
    if (mpop) begin
      check32("inst_pc", inst_pc, exp_stream);
      check32("inst_raw", inst_raw, mem_word(exp_stream));
      last_pop_pc = inst_pc;
      pops++;
      exp_stream += 32'd4;
      exp_fifo--;
    end

    fire = imem_req_valid && imem_req_ready;
    if (imem_rsp_valid) begin
      e = mq.pop_front();
      if (e.live && !redirect_valid) exp_fifo++;
    end

    if (redirect_valid) begin
      tgt        = redirect_pc & 32'hFFFF_FFFC;
      exp_fetch  = tgt;
      exp_stream = tgt;
      exp_fifo   = 0;
      foreach (mq[i]) mq[i].live = 1'b0;
    end
    if (fire) begin
      e.addr = imem_req_addr;
      e.due  = cyc + (rand_mode ? 1 + int'($urandom_range(0, 3)) : d_delay);
      e.live = !redirect_valid;
      mq.push_back(e);
      fires++;
      if (!redirect_valid) exp_fetch += 32'd4;
    end

    boot = 1'b0;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    body();
  endtask

  // Asynchronous reset mid-cycle, check reset outputs, then release into BOOT
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    #1;
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_req_addr", imem_req_addr, RESET_PC);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
    check32("rst_inst_raw", inst_raw, 32'd0);
    mq.delete();
    exp_fetch  = RESET_PC;
    exp_stream = RESET_PC;
    exp_fifo   = 0;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    boot = 1'b1;
    body();
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    rand_mode      = 1'b0;
    d_req_ready    = 1'b1;
    d_inst_ready   = 1'b1;
    d_redirect     = 1'b0;
    d_redirect_pc  = '0;
    d_delay        = 1;
    fires          = 0;
    pops           = 0;
    last_pop_pc    = '0;
    boot           = 1'b0;

    // Basic streaming from reset
    do_reset();
    repeat (12) step();

    // Consumer stalled: exactly two requests, then resume in order
    do_reset();
    d_inst_ready = 1'b0;
    fires = 0;
    repeat (10) step();
    check32("t2_reqs", 32'(fires), 32'd2);
    d_inst_ready = 1'b1;
    repeat (10) step();

    // Redirect with two requests in flight: both stale responses dropped
    do_reset();
    d_delay = 4;
    for (int i = 0; i < 10 && mq.size() < 2; i++) step();
    d_redirect    = 1'b1;
    d_redirect_pc = 32'h0040_0100;
    step();
    pops = 0;
    for (int i = 0; i < 30 && pops == 0; i++) step();
    check32("t3_pops", 32'(pops != 0), 32'd1);
    check32("t3_first_pc", last_pop_pc, 32'h0040_0100);

    // Redirect coinciding with response and pop, one in flight
    do_reset();
    d_delay = 1;
    step();
    step();
    d_redirect    = 1'b1;
    d_redirect_pc = 32'h0040_0100;
    step();
    // Request held while imem is not ready
    d_req_ready = 1'b0;
    step();
    check32("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check32("t4_req_addr", imem_req_addr, 32'h0040_0100);
    repeat (4) step();
    check32("t5_hold_valid", 32'(imem_req_valid), 32'd1);
    check32("t5_hold_addr", imem_req_addr, 32'h0040_0100);
    d_req_ready = 1'b1;
    fires = 0;
    step();
    check32("t5_accept", 32'(fires), 32'd1);
    repeat (6) step();

    // Wrap across the top of the address space
    d_redirect    = 1'b1;
    d_redirect_pc = 32'hFFFF_FFFB;
    step();
    pops = 0;
    repeat (20) step();
    check32("t6_pops", 32'(pops >= 3), 32'd1);

    // Random traffic with periodic resets
    rand_mode = 1'b1;
    pops = 0;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      repeat (1500) step();
    end
    check32("rand_pops", 32'(pops > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
